// File: rtl/stack_pkg.sv
// Shared types for the operand stack: op codes and sticky error codes.
package stack_pkg;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      PUSH = 3'd1,
      POP  = 3'd2,
      TOS  = 3'd3,
      DUP  = 3'd4,
      SWAP = 3'd5,
      DROP = 3'd6
   } op_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      OVF  = 2'd1,
      UNF  = 2'd2
   } err_t;

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: two combinational read ports and two write ports.
module stack_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0,
   input  logic [AW-1:0]    wa0,
   input  logic [WIDTH-1:0] wd0,
   input  logic             we1,
   input  logic [AW-1:0]    wa1,
   input  logic [WIDTH-1:0] wd1,
   input  logic [AW-1:0]    ra0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] rd0,
   output logic [WIDTH-1:0] rd1
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];

endmodule

// File: rtl/stack_unit.sv
// Parametrised operand stack with PUSH/POP/TOS/DUP/SWAP/DROP and occupancy flags.
// Define STACK_UNIT_ERR_EN to build the sticky overflow/underflow reporting on err.
module stack_unit
   import stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic [1:0]       err,
   input  logic             err_clr
);

   localparam int AW = $clog2(DEPTH);

   op_t              op_e;
   logic [AW-1:0]    wr_idx, top_idx, nxt_idx;
   logic [WIDTH-1:0] rd_top, rd_nxt;
   logic             we0, we1;
   logic [AW-1:0]    wa0, wa1;
   logic [WIDTH-1:0] wd0, wd1;
   logic             cnt_inc, cnt_dec, rd_hit;
   logic             fail_ovf, fail_unf;

   assign op_e    = op_t'(op);
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   // Modular index arithmetic: a wrapped top index at count==0 is never consumed.
   assign wr_idx  = count[AW-1:0];
   assign top_idx = wr_idx - AW'(1);
   assign nxt_idx = wr_idx - AW'(2);

   stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
      .clk (clk),
      .we0 (we0),
      .wa0 (wa0),
      .wd0 (wd0),
      .we1 (we1),
      .wa1 (wa1),
      .wd1 (wd1),
      .ra0 (top_idx),
      .ra1 (nxt_idx),
      .rd0 (rd_top),
      .rd1 (rd_nxt)
   );

   always_comb begin
      we0      = 1'b0;
      wa0      = wr_idx;
      wd0      = din;
      we1      = 1'b0;
      wa1      = nxt_idx;
      wd1      = rd_top;
      cnt_inc  = 1'b0;
      cnt_dec  = 1'b0;
      rd_hit   = 1'b0;
      fail_ovf = 1'b0;
      fail_unf = 1'b0;
      if (op_valid) begin
         case (op_e)
            PUSH: if (full) fail_ovf = 1'b1;
                  else begin we0 = 1'b1; cnt_inc = 1'b1; end
            POP:  if (empty) fail_unf = 1'b1;
                  else begin rd_hit = 1'b1; cnt_dec = 1'b1; end
            TOS:  if (empty) fail_unf = 1'b1;
                  else rd_hit = 1'b1;
            DUP:  if (empty) fail_unf = 1'b1;
                  else if (full) fail_ovf = 1'b1;
                  else begin we0 = 1'b1; wd0 = rd_top; cnt_inc = 1'b1; end
            SWAP: if (count < CW'(2)) fail_unf = 1'b1;
                  else begin we0 = 1'b1; wa0 = top_idx; wd0 = rd_nxt; we1 = 1'b1; end
            DROP: if (empty) fail_unf = 1'b1;
                  else cnt_dec = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         if (cnt_inc)      count <= count + CW'(1);
         else if (cnt_dec) count <= count - CW'(1);
         if (rd_hit) dout <= rd_top;
         dout_valid <= rd_hit;
      end
   end

`ifdef STACK_UNIT_ERR_EN
   err_t err_q;

   // First error is held until cleared; a clear coinciding with a new error records the new one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= NONE;
      end else if (fail_ovf) begin
         if (err_q == NONE || err_clr) err_q <= OVF;
      end else if (fail_unf) begin
         if (err_q == NONE || err_clr) err_q <= UNF;
      end else if (err_clr) begin
         err_q <= NONE;
      end
   end

   assign err = err_q;
`else
   logic unused_err;
   assign unused_err = ^{fail_ovf, fail_unf, err_clr};
   assign err        = 2'd0;
`endif

endmodule
